uart_tx_arbiter: RTL and testbench

//  Shares one UART_TX transmitter among NUM_REQ byte sources. Round-robin arbitration;

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ byte sources, with frame pacing timed locally.
// Optional build macro UART_ARB_PRIO_EN: requester 0 gets strict priority, the rest round-robin.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int GUARD_BITS = 12,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      CLK,
  input  logic                      rst_n,
  input  logic [2:0]                bps_sel,
  input  logic                      check_sel,
  input  logic [NUM_REQ-1:0]        src_valid,
  input  logic [NUM_REQ*DATA_W-1:0] src_data,
  output logic [NUM_REQ-1:0]        src_ready,
  output logic [DATA_W-1:0]         tx_din,
  output logic                      tx_req,
  output logic [2:0]                tx_bps_sel,
  output logic                      tx_check_sel,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      frame_done
);

  // state | meaning
  // IDLE  | waiting for any src_valid
  // GRANT | winner accepted (src_ready), byte and line config latched
  // ISSUE | tx_req pulse, timers cleared
  // WAIT  | pacing GUARD_BITS bit periods
  // DONE  | frame_done pulse, advance rr pointer
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   rr_ptr;
  logic [16:0]       bit_cnt;
  logic [3:0]        guard_cnt;
  logic [16:0]       divisor;
  logic              bit_wrap;
  logic              win_found;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   idx;
  logic [DATA_W-1:0] win_data;
  int                j;

  always_comb begin
    case (tx_bps_sel)
      3'd0:    divisor = 17'd83333;
      3'd1:    divisor = 17'd41667;
      3'd2:    divisor = 17'd20833;
      3'd3:    divisor = 17'd10417;
      3'd4:    divisor = 17'd5208;
      3'd5:    divisor = 17'd2604;
      3'd6:    divisor = 17'd1302;
      default: divisor = 17'd83333;
    endcase
  end

  assign bit_wrap = (bit_cnt == divisor - 17'd1);

  // First valid requester at or after the rr pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    idx       = '0;
    j         = 0;
`ifdef UART_ARB_PRIO_EN
    if (src_valid[0]) begin
      win_found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        j = (rr_ptr == '0) ? 1 + k : int'(rr_ptr) + k;
        if (j >= NUM_REQ) j = j - (NUM_REQ - 1);
        idx = ID_W'(j);
        if (!win_found && src_valid[idx]) begin
          win_found = 1'b1;
          winner    = idx;
        end
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = ID_W'(j);
      if (!win_found && src_valid[idx]) begin
        win_found = 1'b1;
        winner    = idx;
      end
    end
`endif
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (winner == ID_W'(i)) win_data = src_data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (win_found) state_nx = S_GRANT;
      S_GRANT: state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (bit_wrap && guard_cnt == 4'(GUARD_BITS - 1)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      src_ready[i] = (state == S_GRANT) && (grant_id == ID_W'(i));
    tx_req     = (state == S_ISSUE);
    frame_done = (state == S_DONE);
    busy       = (state == S_GRANT) || (state == S_ISSUE) || (state == S_WAIT);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      tx_din       <= '0;
      tx_bps_sel   <= 3'd0;
      tx_check_sel <= 1'b0;
      bit_cnt      <= '0;
      guard_cnt    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (win_found) begin
          grant_id     <= winner;
          tx_din       <= win_data;
          tx_bps_sel   <= bps_sel;
          tx_check_sel <= check_sel;
        end
        S_ISSUE: begin
          bit_cnt   <= '0;
          guard_cnt <= '0;
        end
        S_WAIT: begin
          if (bit_wrap) begin
            bit_cnt   <= '0;
            guard_cnt <= guard_cnt + 4'd1;
          end else begin
            bit_cnt <= bit_cnt + 17'd1;
          end
        end
        S_DONE: begin
`ifdef UART_ARB_PRIO_EN
          // Requester 0 is outside the rotation, so its grants leave the pointer alone.
          if (grant_id != '0)
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? ID_W'(1) : grant_id + 1'b1;
`else
          rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized frames
// checked against a transaction-level arbitration/pacing model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int G  = 2;

  logic          CLK = 1'b0;
  logic          rst_n;
  logic [2:0]    bps_sel;
  logic          check_sel;
  logic [N-1:0]  src_valid;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]  src_ready;
  logic [DW-1:0] tx_din;
  logic          tx_req;
  logic [2:0]    tx_bps_sel;
  logic          tx_check_sel;
  logic          busy;
  logic [1:0]    grant_id;
  logic          frame_done;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .GUARD_BITS(G)) dut (
    .CLK(CLK), .rst_n(rst_n), .bps_sel(bps_sel), .check_sel(check_sel),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .tx_din(tx_din), .tx_req(tx_req), .tx_bps_sel(tx_bps_sel),
    .tx_check_sel(tx_check_sel), .busy(busy), .grant_id(grant_id),
    .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int rr_m     = 0;
  int last_w   = -1;
  int div_tab[8] = '{83333, 41667, 20833, 10417, 5208, 2604, 1302, 83333};
  logic [DW-1:0] bytes_q[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m);
    int c;
`ifdef UART_ARB_PRIO_EN
    if (m[0]) return 0;
    for (int k = 0; k < N - 1; k++) begin
      c = ((rr_m == 0 ? 1 : rr_m) - 1 + k) % (N - 1) + 1;
      if (m[c]) return c;
    end
`else
    for (int k = 0; k < N; k++) begin
      c = (rr_m + k) % N;
      if (m[c]) return c;
    end
`endif
    return -1;
  endfunction

  function automatic void advance_rr(input int w);
`ifdef UART_ARB_PRIO_EN
    if (w != 0) rr_m = (w % (N - 1)) + 1;
`else
    rr_m = (w + 1) % N;
`endif
  endfunction

  task automatic load_bytes();
    for (int i = 0; i < N; i++) begin
      bytes_q[i] = DW'($urandom);
      src_data[i*DW +: DW] = bytes_q[i];
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after DONE.
  task automatic do_frame(input logic [N-1:0] mask, input bit hold, input logic [2:0] bps,
                          input logic [2:0] bps_mid, input logic [N-1:0] pulse);
    int w, cyc, n, lim;
    logic [DW-1:0] d;
    logic cs;
    cs = 1'($urandom_range(0, 1));
    bps_sel   = bps;
    check_sel = cs;
    src_valid = mask;
    w = pick(mask);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (src_ready == '0 && cyc < 8);
    check("ready_latency", cyc, 1);
    if (src_ready == '0) return;
    check("src_ready", src_ready, 32'(1 << w));
    check("grant_id", grant_id, w);
    check("busy_grant", busy, 1);
    check("din_grant", tx_din, bytes_q[w]);
    d = bytes_q[w];
    last_w = w;
    if (!hold) src_valid = '0;
    @(negedge CLK);
    check("tx_req", tx_req, 1);
    check("ready_cleared", src_ready, 0);
    check("din_issue", tx_din, d);
    check("bps_latched", tx_bps_sel, bps);
    check("chk_latched", tx_check_sel, cs);
    bps_sel   = bps_mid;
    check_sel = ~cs;
    n = 0;
    lim = G * div_tab[bps] + 50;
    while (frame_done !== 1'b1 && n < lim) begin
      @(negedge CLK);
      n++;
      if (n == 7) src_valid = src_valid | pulse;
      if (n == 8) src_valid = src_valid & ~pulse;
    end
    check("frame_len", n, G * div_tab[bps] + 1);
    check("bps_stable", tx_bps_sel, bps);
    check("chk_stable", tx_check_sel, cs);
    check("din_stable", tx_din, d);
    check("busy_done", busy, 0);
    advance_rr(w);
    @(negedge CLK);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, src_ready, 0);
    check({tag, "_req"}, tx_req, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_gid"}, grant_id, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_din"}, tx_din, 0);
    check({tag, "_bps"}, tx_bps_sel, 0);
    check({tag, "_chk"}, tx_check_sel, 0);
  endtask

  initial begin
    int seq[5];
    rst_n = 1'b0; bps_sel = 3'd6; check_sel = 1'b0; src_valid = '0; src_data = '0;
    repeat (3) @(negedge CLK);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    @(negedge CLK);
    check_idle_outputs("post_rst");

`ifdef UART_ARB_PRIO_EN
    load_bytes();
    for (int f = 0; f < 3; f++) begin
      do_frame(4'b1111, 1'b1, 3'd6, 3'd6, '0);
      check("prio_zero", last_w, 0);
    end
    for (int f = 0; f < 3; f++) begin
      do_frame(4'b1110, 1'b1, 3'd6, 3'd6, '0);
      check("prio_rr", last_w, f + 1);
    end
    src_valid = '0;
`else
    // All four held continuously: strict rotation.
    load_bytes();
    seq = '{0, 1, 2, 3, 0};
    for (int f = 0; f < 5; f++) begin
      do_frame(4'b1111, 1'b1, 3'd6, 3'd6, '0);
      check("rr_seq", last_w, seq[f]);
    end
    src_valid = '0;
`endif

    // Single requester 2 with a fixed byte.
    load_bytes();
    bytes_q[2] = 8'hA5;
    src_data[2*DW +: DW] = 8'hA5;
    do_frame(4'b0100, 1'b0, 3'd6, 3'd6, '0);
    check("single_id", last_w, 2);

    // Baud change mid-frame applies only to the following frame.
    load_bytes();
    do_frame(4'b0001, 1'b0, 3'd6, 3'd5, '0);
    load_bytes();
    do_frame(4'b0010, 1'b0, 3'd5, 3'd5, '0);

    // Requester 1 pulses valid for one cycle while 0 is served, then withdraws.
    load_bytes();
    do_frame(4'b0001, 1'b0, 3'd6, 3'd6, 4'b0010);
    repeat (4) @(negedge CLK);
    check("withdraw_busy", busy, 0);
    check("withdraw_ready", src_ready, 0);

    // Reset in the middle of WAIT.
    load_bytes();
    src_valid = 4'b0001; bps_sel = 3'd6;
    repeat (100) @(negedge CLK);
    src_valid = '0;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge CLK);
    rst_n = 1'b1;
    rr_m = 0;
    @(negedge CLK);
    load_bytes();
    do_frame(4'b0010, 1'b0, 3'd6, 3'd6, '0);
    check("rst_grant", last_w, 1);

    // Randomized masks, data, parity and mid-frame config changes.
    for (int f = 0; f < 6; f++) begin
      load_bytes();
      do_frame(N'($urandom_range(1, 15)), 1'b0, 3'd6, 3'($urandom_range(0, 7)), '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
